// File: rtl/datetime_counter.sv
// datetime_counter: 1 Hz prescaler, Gregorian calendar counter (2025..2999)
// and RUN/SET control for the millennium clock. The SET state supports
// field selection, inc/dec editing and a blink phase for the display.
module datetime_counter #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       sel,
    output logic       set_mode,
    output logic [1:0] set_select,
    output logic       blink,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hour,
    output logic [5:0] day,
    output logic [5:0] month,
    output logic [9:0] year
);

    // Counter widths; both dividers are at least 2, so each width is at least 1.
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
    localparam logic [9:0]    YEAR_LAST  = 10'd974;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    // Gregorian leap rule on the calendar year 2025 + offset.
    function automatic logic is_leap(input logic [9:0] yr);
        logic [11:0] y;
        y = 12'd2025 + {2'b00, yr};
        is_leap = ((y % 12'd4) == 12'd0) &&
                  (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
    endfunction

    // Length of the given month in the given year.
    function automatic logic [5:0] days_in_month(input logic [5:0] mo,
                                                 input logic [9:0] yr);
        case (mo)
            6'd4, 6'd6, 6'd9, 6'd11: days_in_month = 6'd30;
            6'd2: begin
                if (is_leap(yr)) begin
                    days_in_month = 6'd29;
                end else begin
                    days_in_month = 6'd28;
                end
            end
            default: days_in_month = 6'd31;
        endcase
    endfunction

    // One step up or down inside [lo, hi], wrapping at both ends.
    function automatic logic [5:0] step_wrap6(input logic [5:0] v,
                                              input logic [5:0] lo,
                                              input logic [5:0] hi,
                                              input logic       up);
        if (up) begin
            if (v >= hi) begin
                step_wrap6 = lo;
            end else begin
                step_wrap6 = v + 6'd1;
            end
        end else begin
            if (v <= lo) begin
                step_wrap6 = hi;
            end else begin
                step_wrap6 = v - 6'd1;
            end
        end
    endfunction

    // Year offset step, wrapping 974 <-> 0.
    function automatic logic [9:0] step_year(input logic [9:0] y,
                                             input logic       up);
        if (up) begin
            if (y >= YEAR_LAST) begin
                step_year = 10'd0;
            end else begin
                step_year = y + 10'd1;
            end
        end else begin
            if (y == 10'd0) begin
                step_year = YEAR_LAST;
            end else begin
                step_year = y - 10'd1;
            end
        end
    endfunction

    // Keep a day inside a (possibly shorter) month.
    function automatic logic [5:0] clamp_day(input logic [5:0] d,
                                             input logic [5:0] lim);
        if (d > lim) begin
            clamp_day = lim;
        end else begin
            clamp_day = d;
        end
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [TW-1:0]   presc_r;
    logic [BW-1:0]   blink_cnt_r;
    logic            blink_r;
    logic [1:0]      set_select_r;
    logic [5:0]      sec_r, min_r, hour_r, day_r, month_r;
    logic [9:0]      year_r;
    logic [5:0]      sec_s, min_s, hour_s, day_s, month_s;
    logic [9:0]      year_s;
    logic            tick_s;
    logic            edit_s;
    logic            advance_s;
    logic [2:0]      field_s;
    logic [5:0]      dim_cur_s;
    logic [5:0]      month_step_s;
    logic [9:0]      year_step_s;

    // Tick only counts in RUN; edits only in SET and never alongside btn_mode.
    // Simultaneous inc and dec cancel out and are not treated as an edit.
    assign tick_s       = (state_r == ST_RUN) && (presc_r == TICK_LAST);
    assign edit_s       = (state_r == ST_SET) && !btn_mode && (btn_inc ^ btn_dec);
    assign advance_s    = (state_r == ST_SET) && !btn_mode && btn_next;
    assign field_s      = {sel, set_select_r};
    assign dim_cur_s    = days_in_month(month_r, year_r);
    assign month_step_s = step_wrap6(month_r, 6'd1, 6'd12, btn_inc);
    assign year_step_s  = step_year(year_r, btn_inc);

    // Next-state logic for the RUN/SET machine.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (btn_mode) begin
                    state_next_s = ST_SET;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SET: begin
                if (btn_mode) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_SET;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Second prescaler: free-runs in RUN, held at zero in SET and on any mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else if ((state_r != ST_RUN) || btn_mode || (presc_r == TICK_LAST)) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + TICK_ONE;
        end
    end

    // Blink phase: toggles in SET, forced low in RUN, restarted by entry and edits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if ((state_r == ST_RUN) && btn_mode) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if ((state_r == ST_RUN) || btn_mode) begin
            blink_r <= 1'b0;
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= '0;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            end
        end else if (edit_s) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
        end
    end

    // Field selector: cleared on SET entry, cycles 0->1->2->0 on btn_next in SET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_select_r <= 2'd0;
        end else if ((state_r == ST_RUN) && btn_mode) begin
            set_select_r <= 2'd0;
        end else if (advance_s) begin
            if (set_select_r >= 2'd2) begin
                set_select_r <= 2'd0;
            end else begin
                set_select_r <= set_select_r + 2'd1;
            end
        end else begin
            set_select_r <= set_select_r;
        end
    end

    // Calendar next values: carry chain on tick in RUN, single-field edits in SET.
    always_comb begin
        sec_s   = sec_r;
        min_s   = min_r;
        hour_s  = hour_r;
        day_s   = day_r;
        month_s = month_r;
        year_s  = year_r;
        if (tick_s) begin
            if (sec_r == 6'd59) begin
                sec_s = 6'd0;
                if (min_r == 6'd59) begin
                    min_s = 6'd0;
                    if (hour_r == 6'd23) begin
                        hour_s = 6'd0;
                        if (day_r >= dim_cur_s) begin
                            day_s = 6'd1;
                            if (month_r == 6'd12) begin
                                month_s = 6'd1;
                                year_s  = step_year(year_r, 1'b1);
                            end else begin
                                month_s = month_r + 6'd1;
                            end
                        end else begin
                            day_s = day_r + 6'd1;
                        end
                    end else begin
                        hour_s = hour_r + 6'd1;
                    end
                end else begin
                    min_s = min_r + 6'd1;
                end
            end else begin
                sec_s = sec_r + 6'd1;
            end
        end else if (edit_s) begin
            case (field_s)
                3'b000: sec_s  = step_wrap6(sec_r, 6'd0, 6'd59, btn_inc);
                3'b001: min_s  = step_wrap6(min_r, 6'd0, 6'd59, btn_inc);
                3'b010: hour_s = step_wrap6(hour_r, 6'd0, 6'd23, btn_inc);
                3'b100: day_s  = step_wrap6(day_r, 6'd1, dim_cur_s, btn_inc);
                3'b101: begin
                    // A shorter target month pulls the day down in the same cycle.
                    month_s = month_step_s;
                    day_s   = clamp_day(day_r, days_in_month(month_step_s, year_r));
                end
                3'b110: begin
                    // Leaving a leap year can shorten February.
                    year_s = year_step_s;
                    day_s  = clamp_day(day_r, days_in_month(month_r, year_step_s));
                end
                default: sec_s = sec_r;
            endcase
        end else begin
            sec_s = sec_r;
        end
    end

    // Calendar registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_r   <= 6'd0;
            min_r   <= 6'd0;
            hour_r  <= 6'd0;
            day_r   <= 6'd1;
            month_r <= 6'd1;
            year_r  <= 10'd0;
        end else begin
            sec_r   <= sec_s;
            min_r   <= min_s;
            hour_r  <= hour_s;
            day_r   <= day_s;
            month_r <= month_s;
            year_r  <= year_s;
        end
    end

    assign set_mode   = (state_r == ST_SET);
    assign set_select = set_select_r;
    assign blink      = blink_r;
    assign sec        = sec_r;
    assign min        = min_r;
    assign hour       = hour_r;
    assign day        = day_r;
    assign month      = month_r;
    assign year       = year_r;

endmodule

// File: tb/tb_datetime_counter.sv
// Directed bench for datetime_counter with small dividers. Expected values
// are queued as each step is driven and popped/compared after the step.
module tb_datetime_counter;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 8;

    localparam int K_SEC = 0, K_MIN = 1, K_HOUR = 2, K_DAY = 3, K_MONTH = 4;
    localparam int K_YEAR = 5, K_MODE = 6, K_SELECT = 7, K_BLINK = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_next, btn_inc, btn_dec, sel;
    logic       set_mode;
    logic [1:0] set_select;
    logic       blink;
    logic [5:0] sec, min, hour, day, month;
    logic [9:0] year;

    int vectors     = 0;
    int miscompares = 0;
    int cur_idx     = 0;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       tag_q[$];

    datetime_counter #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .sel(sel), .set_mode(set_mode), .set_select(set_select), .blink(blink),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observe(input int k);
        case (k)
            K_SEC:    observe = {26'd0, sec};
            K_MIN:    observe = {26'd0, min};
            K_HOUR:   observe = {26'd0, hour};
            K_DAY:    observe = {26'd0, day};
            K_MONTH:  observe = {26'd0, month};
            K_YEAR:   observe = {22'd0, year};
            K_MODE:   observe = {31'd0, set_mode};
            K_SELECT: observe = {30'd0, set_select};
            K_BLINK:  observe = {31'd0, blink};
            default:  observe = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int k, input int v);
        tag_q.push_back(tag);
        kind_q.push_back(k);
        exp_q.push_back(32'(v));
    endtask

    task automatic expect_time(input string tag, input int h, input int m, input int s);
        expect_val({tag, ".hour"}, K_HOUR, h);
        expect_val({tag, ".min"}, K_MIN, m);
        expect_val({tag, ".sec"}, K_SEC, s);
    endtask

    task automatic expect_date(input string tag, input int d, input int mo, input int y);
        expect_val({tag, ".day"}, K_DAY, d);
        expect_val({tag, ".month"}, K_MONTH, mo);
        expect_val({tag, ".year"}, K_YEAR, y);
    endtask

    task automatic expect_reset(input string tag);
        expect_time(tag, 0, 0, 0);
        expect_date(tag, 1, 1, 0);
        expect_val({tag, ".set_mode"}, K_MODE, 0);
        expect_val({tag, ".set_select"}, K_SELECT, 0);
        expect_val({tag, ".blink"}, K_BLINK, 0);
    endtask

    task automatic check_all();
        while (kind_q.size() > 0) begin
            int          k;
            logic [31:0] e;
            logic [31:0] o;
            string       t;
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observe(k);
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", t, o, e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic m, input logic n, input logic i, input logic d);
        btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d;
        step(1);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic press_rep(input logic i, input logic d, input int cnt);
        for (int r = 0; r < cnt; r++) press(1'b0, 1'b0, i, d);
    endtask

    task automatic next_to(input int idx);
        while (cur_idx != idx) begin
            press(1'b0, 1'b1, 1'b0, 1'b0);
            cur_idx = (cur_idx + 1) % 3;
        end
    endtask

    task automatic enter_set();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        cur_idx = 0;
    endtask

    initial begin
        rst_n = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        sel = 1'b0;
        #12;
        expect_reset("reset");
        check_all();
        rst_n = 1'b1;

        // First tick lands on the 4th edge, one hour after 4*3600 edges.
        step(3);
        expect_val("pre_tick.sec", K_SEC, 0);
        check_all();
        step(1);
        expect_val("first_tick.sec", K_SEC, 1);
        check_all();
        step(4 * 3600 - 4);
        expect_time("one_hour", 1, 0, 0);
        expect_date("one_hour", 1, 1, 0);
        check_all();

        // Editing buttons are ignored in RUN.
        press(1'b0, 1'b1, 1'b1, 1'b0);
        expect_time("run_ignore", 1, 0, 0);
        expect_val("run_ignore.set_select", K_SELECT, 0);
        expect_val("run_ignore.set_mode", K_MODE, 0);
        check_all();

        // Year rollover: preload 2025-12-31 23:59:59.
        enter_set();
        expect_val("enter_set.set_mode", K_MODE, 1);
        expect_val("enter_set.set_select", K_SELECT, 0);
        expect_val("enter_set.blink", K_BLINK, 0);
        check_all();
        sel = 1'b1;
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        sel = 1'b0;
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(2); press_rep(1'b0, 1'b1, 2);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_time("preload_ny", 23, 59, 59);
        expect_date("preload_ny", 31, 12, 0);
        expect_val("exit_set.set_mode", K_MODE, 0);
        check_all();
        step(3);
        expect_val("ny_hold.sec", K_SEC, 59);
        check_all();
        step(1);
        expect_time("new_year", 0, 0, 0);
        expect_date("new_year", 1, 1, 1);
        check_all();

        // Leap year 2028: Feb 28 -> Feb 29.
        enter_set();
        sel = 1'b1;
        next_to(2); press_rep(1'b1, 1'b0, 2);
        next_to(1); press(1'b0, 1'b0, 1'b1, 1'b0);
        next_to(0); press_rep(1'b0, 1'b1, 2);
        sel = 1'b0;
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(2); press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_date("pre_2028", 28, 2, 3);
        check_all();
        step(4);
        expect_time("leap_2028", 0, 0, 0);
        expect_date("leap_2028", 29, 2, 3);
        check_all();

        // 2100 is not leap: Feb 28 -> Mar 1.
        enter_set();
        sel = 1'b1;
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(2); press_rep(1'b1, 1'b0, 72);
        sel = 1'b0;
        next_to(2); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_time("pre_2100", 23, 59, 59);
        expect_date("pre_2100", 28, 2, 75);
        check_all();
        step(4);
        expect_date("nonleap_2100", 1, 3, 75);
        check_all();

        // 2400 is leap: Feb 28 -> Feb 29.
        enter_set();
        sel = 1'b1;
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(2); press_rep(1'b1, 1'b0, 300);
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        expect_val("dec_day_2400.day", K_DAY, 29);
        check_all();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        sel = 1'b0;
        next_to(0); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        next_to(2); press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        step(4);
        expect_time("leap_2400", 0, 0, 0);
        expect_date("leap_2400", 29, 2, 375);
        check_all();

        // Editing: clamping, month wrap, year wrap, inc+dec cancel.
        enter_set();
        sel = 1'b1;
        next_to(1); press(1'b0, 1'b0, 1'b1, 1'b0);
        next_to(0); press_rep(1'b1, 1'b0, 2);
        expect_date("mar31", 31, 3, 375);
        check_all();
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        expect_date("clamp_leap", 29, 2, 375);
        check_all();
        next_to(2); press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_date("clamp_year", 28, 2, 376);
        check_all();
        next_to(1); press(1'b0, 1'b0, 1'b0, 1'b1);
        expect_val("month_dec.month", K_MONTH, 1);
        check_all();
        press(1'b0, 1'b0, 1'b0, 1'b1);
        expect_date("month_wrap", 28, 12, 376);
        check_all();
        next_to(2); press_rep(1'b1, 1'b0, 598);
        expect_val("year_max.year", K_YEAR, 974);
        check_all();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_date("year_wrap", 28, 12, 0);
        check_all();
        press(1'b0, 1'b0, 1'b1, 1'b1);
        expect_date("inc_dec_both", 28, 12, 0);
        expect_time("inc_dec_both", 0, 0, 0);
        check_all();

        // Blink and select behaviour.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_val("run.blink", K_BLINK, 0);
        expect_val("run.set_mode", K_MODE, 0);
        check_all();
        enter_set();
        step(7);
        expect_val("blink_7.blink", K_BLINK, 0);
        check_all();
        step(1);
        expect_val("blink_8.blink", K_BLINK, 1);
        check_all();
        step(7);
        expect_val("blink_15.blink", K_BLINK, 1);
        check_all();
        step(1);
        expect_val("blink_16.blink", K_BLINK, 0);
        check_all();
        step(8);
        expect_val("blink_24.blink", K_BLINK, 1);
        check_all();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_val("edit_restart.blink", K_BLINK, 0);
        expect_val("edit_restart.day", K_DAY, 29);
        check_all();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        expect_val("next1.set_select", K_SELECT, 1);
        check_all();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        expect_val("next2.set_select", K_SELECT, 2);
        check_all();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        expect_val("next3.set_select", K_SELECT, 0);
        check_all();
        cur_idx = 0;
        press(1'b1, 1'b0, 1'b1, 1'b0);
        expect_val("mode_inc.set_mode", K_MODE, 0);
        expect_val("mode_inc.blink", K_BLINK, 0);
        expect_date("mode_inc", 29, 12, 0);
        expect_time("mode_inc", 0, 0, 0);
        check_all();

        // Asynchronous reset in the middle of SET, between clock edges.
        enter_set();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_val("pre_rst.day", K_DAY, 30);
        expect_val("pre_rst.set_mode", K_MODE, 1);
        check_all();
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("async_rst");
        check_all();
        #2;
        rst_n = 1'b1;
        step(3);
        expect_val("post_rst_pre.sec", K_SEC, 0);
        expect_val("post_rst_pre.set_mode", K_MODE, 0);
        check_all();
        step(1);
        expect_val("post_rst_tick.sec", K_SEC, 1);
        expect_date("post_rst_tick", 1, 1, 0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
